// File: rtl/mux_n_rr.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage that sustains one word per cycle.
module mux_n_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           mode_i,
    input  logic [SW-1:0]  sel_i,
    input  logic [N*W-1:0] in_data_i,
    input  logic [N-1:0]   in_valid_i,
    output logic [N-1:0]   in_ready_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SW-1:0]  out_ch_o
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_ok;
    logic          grant;
    logic [SW-1:0] grant_idx;
    logic          rr_found;
    int            rr_idx;

    // The stage can accept a new word when empty or when its word leaves this cycle.
    assign load_ok = !out_valid_q || out_ready_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        grant     = 1'b0;
        grant_idx = '0;
        rr_found  = 1'b0;
        rr_idx    = 0;
        if (!rst_i && load_ok) begin
            if (!mode_i) begin
                // Only the selected channel's own valid is looked at here.
                if (int'(sel_i) < N && in_valid_i[sel_i]) begin
                    grant     = 1'b1;
                    grant_idx = sel_i;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    rr_idx = (int'(ptr_q) + i) % N;
                    if (!rr_found && in_valid_i[rr_idx]) begin
                        rr_found  = 1'b1;
                        grant_idx = SW'(rr_idx);
                    end
                end
                grant = rr_found;
            end
        end
    end

    assign in_ready_o = grant ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i[grant_idx*W +: W];
            out_ch_d    = grant_idx;
            if (mode_i) begin
                ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from the values seen before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: doc/mux_n_rr.md
MUX_N_RR -- requirements
Module: mux_n_rr

Interface
REQ-001 SHALL provide parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL provide parameter W, default 8, data width per channel (1..32).
REQ-003 SHALL derive local parameter SW = max(1, clog2(N)), channel index width.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port MODE  input  1  0 = fixed select via SEL, 1 = round-robin.
REQ-007 SHALL have port SEL  input  SW  channel index used when MODE = 0.
REQ-008 SHALL have port IN_DATA  input  N*W  channel k data at bits [k*W+W-1 : k*W].
REQ-009 SHALL have port IN_VALID  input  N  per-channel valid.
REQ-010 SHALL have port IN_READY  output  N  per-channel ready, combinational.
REQ-011 SHALL have port OUT_DATA  output  W  registered selected data.
REQ-012 SHALL have port OUT_VALID  output  1  registered; OUT_DATA/OUT_CH hold a word.
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts the word.
REQ-014 SHALL have port OUT_CH  output  SW  registered index of the channel OUT_DATA came from.

Function
REQ-015 SHALL hold one internal register stage (OUT_DATA, OUT_CH, OUT_VALID) and a round-robin pointer PTR (SW bits, range 0..N-1).
REQ-016 SHALL define LOAD_OK = !OUT_VALID || OUT_READY (stage empty or draining this cycle).
REQ-017 In MODE = 0, SHALL grant channel SEL iff SEL < N, IN_VALID[SEL] = 1 and LOAD_OK = 1; otherwise no grant.
REQ-018 In MODE = 1, SHALL grant the first channel k with IN_VALID[k] = 1, searching PTR, PTR+1, ... modulo N, iff LOAD_OK = 1.
REQ-019 SHALL drive IN_READY one-hot on the granted channel and all-zero when no grant; IN_READY SHALL NOT depend on IN_VALID of other channels in MODE = 0.
REQ-020 A transfer SHALL occur on channel k when IN_VALID[k] and IN_READY[k] are both 1 at a rising CLK edge.
REQ-021 On a transfer, next cycle SHALL have OUT_DATA = channel k data, OUT_CH = k, OUT_VALID = 1 (latency exactly 1 cycle).
REQ-022 If OUT_VALID = 1, OUT_READY = 1 and no transfer occurs, OUT_VALID SHALL go 0; OUT_DATA and OUT_CH SHALL hold their last values.
REQ-023 If OUT_VALID = 1 and OUT_READY = 0, OUT_DATA, OUT_CH, OUT_VALID SHALL hold and all IN_READY SHALL be 0.
REQ-024 Simultaneous drain and load (OUT_VALID = 1, OUT_READY = 1, transfer) SHALL replace the word with no bubble; full throughput = one word per cycle.
REQ-025 On a MODE = 1 transfer from channel k, PTR SHALL become (k+1) mod N, wrapping N-1 -> 0.
REQ-026 PTR SHALL hold when no transfer occurs and on all MODE = 0 transfers.
REQ-027 MODE and SEL changes SHALL take effect combinationally for the current cycle's grant; a word already in the register SHALL be unaffected.
REQ-028 With all IN_VALID = 0, SHALL make no transfer and no PTR change.
REQ-029 SEL >= N (non-power-of-2 N) SHALL produce no grant and no error state.

Reset
REQ-030 RST = 1 SHALL immediately force OUT_VALID = 0, OUT_DATA = 0, OUT_CH = 0, PTR = 0, independent of CLK.
REQ-031 While RST = 1, IN_READY SHALL be all-zero; a word held mid-handshake SHALL be discarded.
REQ-032 First grant SHALL be possible at the first rising CLK edge after RST deasserts.

Verification (N = 4, W = 8)
REQ-033 Fixed select: MODE=0, SEL=2, IN_VALID=4'b1111, data A..D = 0x11,0x22,0x33,0x44, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_DATA=0x33, OUT_CH=2, OUT_VALID=1.
REQ-034 Round-robin fairness: MODE=1, IN_VALID=4'b1111 held, OUT_READY=1, from reset -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles, OUT_VALID continuously 1.
REQ-035 Backpressure: word 0x22 held with OUT_READY=0 for 3 cycles -> OUT_DATA stays 0x22, IN_READY=0 throughout; OUT_READY=1 -> next word loads with no bubble.
REQ-036 Sparse/wrap: MODE=1, PTR=3, IN_VALID=4'b0010 -> grant channel 1, PTR becomes 2; IN_VALID=0 -> no transfer, OUT_VALID drops after drain.
REQ-037 Invalid select: MODE=0, SEL=2, IN_VALID=4'b1011 -> IN_READY=0, no transfer, PTR unchanged.
REQ-038 Async reset mid-operation: assert RST between edges with OUT_VALID=1 -> OUT_VALID, OUT_DATA, OUT_CH, PTR = 0 before next edge; after release, MODE=1 round-robin restarts at channel 0.
